// File: rtl/key_cmd_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_fifo_pkg
//  Description : Shared constants for the keypad command front end: keycodes,
//                scan length, column patterns and per-key index order.
//  Revision    : 1.0  initial release
// ============================================================================
package key_cmd_fifo_pkg;

    // Command codes handed to the movement logic
    localparam logic [3:0] KEY_NONE  = 4'd0;
    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_LEFT  = 4'd4;
    localparam logic [3:0] KEY_RIGHT = 4'd6;
    localparam logic [3:0] KEY_DOWN  = 4'd8;

    // Last select value of a scan frame (frame = SCAN_LAST+1 cycles)
    localparam logic [2:0] SCAN_LAST = 3'd5;

    // Active-low column patterns, one column pulled low
    localparam logic [2:0] COL_L = 3'b011;
    localparam logic [2:0] COL_M = 3'b101;
    localparam logic [2:0] COL_R = 3'b110;

    localparam int NUM_KEYS = 4;

    // Key indices, ordered by push priority (lowest index wins)
    typedef enum logic [1:0] {
        IDX_UP    = 2'd0,
        IDX_DOWN  = 2'd1,
        IDX_LEFT  = 2'd2,
        IDX_RIGHT = 2'd3
    } key_idx_t;

endpackage
`default_nettype wire

// File: rtl/key_cmd_fifo_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Per-key frame debouncer. Counts consecutive disagreeing
//                evaluations, flips the debounced state after DEB_FRAMES of
//                them and pulses press on every 0->1 transition.
//                With KEY_REPEAT_EN defined, a held key also pulses press
//                every REPEAT_FRAMES evaluations.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import key_cmd_fifo_pkg::*;
#(
    parameter int DEB_FRAMES    = 4
`ifdef KEY_REPEAT_EN
    ,
    parameter int REPEAT_FRAMES = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic eval,
    input  logic raw,
    output logic press
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES - 1);

    logic [3:0] cnt;
    logic       state;
    logic       flip;
    logic       rise;

    // The debounced state changes on the evaluation where the count would hit DEB_FRAMES
    assign flip = eval && (raw != state) && (cnt == DEB_LAST);
    assign rise = flip && !state;

    // Disagreement counter and debounced state, updated once per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 4'd0;
            state <= 1'b0;
        end else if (eval) begin
            if (raw == state) begin
                cnt <= 4'd0;
            end else if (cnt == DEB_LAST) begin
                state <= raw;
                cnt   <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int             RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_FRAMES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_fire;

    // Repeat fires only while the key stays held through this evaluation
    assign rep_fire = eval && state && !flip && (rep_cnt == REP_LAST);

    // Repeat counter: idle while released, restarts on press, release and each fire
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else if (eval) begin
            if (!state || flip || (rep_cnt == REP_LAST)) begin
                rep_cnt <= '0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    assign press = rise | rep_fire;
`else
    assign press = rise;
`endif

endmodule
`default_nettype wire

// File: rtl/key_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_cmd_fifo
//  Description : Keypad scanner, four-key debounce and command queue with a
//                valid/ready consumer handshake. Each debounced press becomes
//                one 4-bit command; a push into a full queue is dropped and
//                latches the sticky overflow flag.
//                Optional build macro KEY_REPEAT_EN enables auto-repeat.
//  Revision    : 1.0  initial release
// ============================================================================
module key_cmd_fifo
    import key_cmd_fifo_pkg::*;
#(
    parameter int DEB_FRAMES    = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] column,
    output logic [2:0] sel,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [3:0] keycode,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] grant;
    logic [3:0]          push_code;
    logic                eval;

    logic [3:0]          mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr;
    logic [AW:0]         rd_ptr;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push_req;
    logic                push_ok;

    // Row select walks 0..SCAN_LAST, one row per scan tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel <= 3'd0;
        end else if (sel == SCAN_LAST) begin
            sel <= 3'd0;
        end else begin
            sel <= sel + 3'd1;
        end
    end

    // Capture each key's raw level while its row is selected
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raw <= '0;
        end else begin
            case (sel)
                3'd0: raw[IDX_UP] <= (column == COL_M);
                3'd1: begin
                    raw[IDX_LEFT]  <= (column == COL_L);
                    raw[IDX_RIGHT] <= (column == COL_R);
                end
                3'd2: raw[IDX_DOWN] <= (column == COL_M);
                default: ;
            endcase
        end
    end

    assign eval = (sel == SCAN_LAST);

    generate
        for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
            key_debounce #(
                .DEB_FRAMES    (DEB_FRAMES)
`ifdef KEY_REPEAT_EN
                ,
                .REPEAT_FRAMES (REPEAT_FRAMES)
`endif
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .eval  (eval),
                .raw   (raw[i]),
                .press (press[i])
            );
        end
    endgenerate

    // Pick the highest-priority pending key: up > down > left > right
    always_comb begin
        grant     = '0;
        push_code = KEY_NONE;
        if (pending[IDX_UP]) begin
            grant[IDX_UP] = 1'b1;
            push_code     = KEY_UP;
        end else if (pending[IDX_DOWN]) begin
            grant[IDX_DOWN] = 1'b1;
            push_code       = KEY_DOWN;
        end else if (pending[IDX_LEFT]) begin
            grant[IDX_LEFT] = 1'b1;
            push_code       = KEY_LEFT;
        end else if (pending[IDX_RIGHT]) begin
            grant[IDX_RIGHT] = 1'b1;
            push_code        = KEY_RIGHT;
        end
    end

    // Pending bits: set by press pulses, the granted one clears even if the push is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~grant) | press;
        end
    end

    // Extra pointer bit distinguishes full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop      = !empty && cmd_ready;
    assign push_req = |pending;
    assign push_ok  = push_req && (!full || pop);

    // Queue pointers and sticky overflow; a pop at full makes room for a same-cycle push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Command storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_code;
        end
    end

    assign cmd_valid = !empty;
    assign keycode   = empty ? KEY_NONE : mem[rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_key_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_cmd_fifo
//  Description : Self-checking bench for key_cmd_fifo. A cycle-level reference
//                model built from queues and per-key frame counters predicts
//                sel, cmd_valid, keycode and overflow every cycle; directed
//                scenarios add transfer-count and latency checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_cmd_fifo;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int REP   = 16;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic [2:0] column;
    logic [2:0] sel;
    logic       cmd_valid;
    logic       cmd_ready = 1'b0;
    logic [3:0] keycode;
    logic       overflow;

    // 0 none, 1 up, 2 left, 3 right, 4 down, 5 random column noise
    int         key_now    = 0;
    logic [2:0] noise      = 3'b111;
    // 0 never ready, 1 always, 2 random, 3 only when a push is due
    int         ready_mode = 0;

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its column low only on its own row
    always_comb begin
        column = 3'b111;
        case (key_now)
            1: if (sel == 3'd0) column = 3'b101;
            2: if (sel == 3'd1) column = 3'b011;
            3: if (sel == 3'd1) column = 3'b110;
            4: if (sel == 3'd2) column = 3'b101;
            5: column = noise;
            default: ;
        endcase
    end

    key_cmd_fifo #(
        .DEB_FRAMES    (DEB),
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_FRAMES (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .column    (column),
        .sel       (sel),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .keycode   (keycode),
        .overflow  (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model state, keys ordered up, down, left, right
    int m_sel;
    bit m_raw  [4];
    int m_cnt  [4];
    bit m_st   [4];
    bit m_pend [4];
    int m_rep  [4];
    int m_q    [$];
    bit m_ovf;
    int codes  [4] = '{2, 8, 4, 6};

    int xfers;
    int xfer_log [$];
    int cyc;
    int first_valid;
    int valid_cycles;

    task automatic model_reset();
        m_sel = 0;
        m_ovf = 1'b0;
        m_q.delete();
        for (int i = 0; i < 4; i++) begin
            m_raw[i]  = 1'b0;
            m_cnt[i]  = 0;
            m_st[i]   = 1'b0;
            m_pend[i] = 1'b0;
            m_rep[i]  = 0;
        end
    endtask

    // One cycle: called at a falling edge, checks outputs, advances the model, returns at the next falling edge
    task automatic step();
        int pushc;
        bit pop;
        case (ready_mode)
            0: cmd_ready = 1'b0;
            1: cmd_ready = 1'b1;
            2: cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
        endcase
        if (key_now == 5) noise = 3'($urandom);
        #1;
        check_eq("sel", int'(sel), m_sel);
        check_eq("cmd_valid", int'(cmd_valid), int'(m_q.size() > 0));
        check_eq("keycode", int'(keycode), (m_q.size() > 0) ? m_q[0] : 0);
        check_eq("overflow", int'(overflow), int'(m_ovf));
        if (cmd_valid && first_valid < 0) first_valid = cyc;
        if (cmd_valid) valid_cycles++;
        if (cmd_valid && cmd_ready) begin
            xfers++;
            xfer_log.push_back(int'(keycode));
        end

        pop   = (m_q.size() > 0) && cmd_ready;
        pushc = -1;
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && pushc < 0) begin
                pushc     = codes[i];
                m_pend[i] = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (pushc >= 0) begin
            if (m_q.size() < DEPTH) m_q.push_back(pushc);
            else m_ovf = 1'b1;
        end

        case (m_sel)
            0: m_raw[0] = (column == 3'b101);
            1: begin
                m_raw[2] = (column == 3'b011);
                m_raw[3] = (column == 3'b110);
            end
            2: m_raw[1] = (column == 3'b101);
            default: ;
        endcase

        if (m_sel == 5) begin
            for (int i = 0; i < 4; i++) begin
                bit old;
                old = m_st[i];
                if (m_raw[i] == old) begin
                    m_cnt[i] = 0;
                end else begin
                    m_cnt[i]++;
                    if (m_cnt[i] == DEB) begin
                        m_st[i]  = !old;
                        m_cnt[i] = 0;
                    end
                end
                if (!old && m_st[i]) begin
                    m_pend[i] = 1'b1;
                    m_rep[i]  = 0;
                end else if (old && m_st[i]) begin
`ifdef KEY_REPEAT_EN
                    m_rep[i]++;
                    if (m_rep[i] == REP) begin
                        m_pend[i] = 1'b1;
                        m_rep[i]  = 0;
                    end
`endif
                end else begin
                    m_rep[i] = 0;
                end
            end
        end

        m_sel = (m_sel == 5) ? 0 : m_sel + 1;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold(input int key, input int cycles);
        key_now = key;
        repeat (cycles) step();
    endtask

    task automatic align();
        while (m_sel != 0) step();
    endtask

    initial begin
        int c0;
        int exp_rep;
        xfers        = 0;
        cyc          = 0;
        first_valid  = -1;
        valid_cycles = 0;
        model_reset();

        // Reset values
        #1 reset = 1'b1;
        #1;
        check_eq("rst_sel", int'(sel), 0);
        check_eq("rst_valid", int'(cmd_valid), 0);
        check_eq("rst_keycode", int'(keycode), 0);
        check_eq("rst_overflow", int'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Up held 10 frames, consumer always ready: one transfer, fixed latency
        align();
        ready_mode   = 1;
        xfers        = 0;
        xfer_log.delete();
        first_valid  = -1;
        valid_cycles = 0;
        c0           = cyc;
        hold(1, 60);
        hold(0, 36);
        check_eq("up_xfers", xfers, 1);
        check_eq("up_code", (xfer_log.size() > 0) ? xfer_log[0] : -1, 2);
        check_eq("up_valid_cycles", valid_cycles, 1);
        check_eq("up_latency", first_valid - c0, 6 * (DEB - 1) + 7);

        // Left glitch shorter than the debounce window
        align();
        xfers = 0;
        hold(2, 18);
        hold(0, 36);
        check_eq("glitch_xfers", xfers, 0);
        check_eq("glitch_left_state", int'(dut.g_key[2].u_deb.state), 0);

        // Left then right, consumer stalled, then drained back to back
        ready_mode = 0;
        align();
        hold(2, 30);
        hold(3, 30);
        hold(0, 30);
        check_eq("lr_head", int'(keycode), 4);
        xfers = 0;
        xfer_log.delete();
        ready_mode = 1;
        hold(0, 2);
        check_eq("lr_xfers", xfers, 2);
        check_eq("lr_first", (xfer_log.size() > 0) ? xfer_log[0] : -1, 4);
        check_eq("lr_second", (xfer_log.size() > 1) ? xfer_log[1] : -1, 6);
        hold(0, 30);

        // Fill the queue, push+pop at full, then a dropped push
        ready_mode = 0;
        xfers      = 0;
        xfer_log.delete();
        hold(1, 30); hold(0, 30);
        hold(4, 30); hold(0, 30);
        hold(2, 30); hold(0, 30);
        hold(3, 30); hold(0, 30);
        check_eq("full_overflow", int'(overflow), 0);
        ready_mode = 3;
        hold(1, 30);
        ready_mode = 0;
        hold(0, 30);
        check_eq("pushpop_overflow", int'(overflow), 0);
        check_eq("pushpop_pops", xfers, 1);
        hold(4, 30);
        hold(0, 30);
        check_eq("drop_overflow", int'(overflow), 1);
        xfers = 0;
        xfer_log.delete();
        ready_mode = 1;
        hold(0, 6);
        check_eq("drain_count", xfers, 4);
        check_eq("drain_0", (xfer_log.size() > 0) ? xfer_log[0] : -1, 8);
        check_eq("drain_1", (xfer_log.size() > 1) ? xfer_log[1] : -1, 4);
        check_eq("drain_2", (xfer_log.size() > 2) ? xfer_log[2] : -1, 6);
        check_eq("drain_3", (xfer_log.size() > 3) ? xfer_log[3] : -1, 2);
        check_eq("drain_overflow_sticky", int'(overflow), 1);

        // Asynchronous reset mid-frame with three queued commands
        ready_mode = 0;
        hold(1, 30); hold(0, 30);
        hold(4, 30); hold(0, 30);
        hold(2, 30); hold(0, 30);
        while (m_sel != 3) step();
        check_eq("prerst_valid", int'(cmd_valid), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", int'(cmd_valid), 0);
        check_eq("arst_keycode", int'(keycode), 0);
        check_eq("arst_sel", int'(sel), 0);
        check_eq("arst_overflow", int'(overflow), 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold(0, 12);

        // Long hold of down: auto-repeat when enabled, single command otherwise
`ifdef KEY_REPEAT_EN
        exp_rep = 3;
`else
        exp_rep = 1;
`endif
        align();
        ready_mode = 1;
        xfers      = 0;
        xfer_log.delete();
        hold(4, 240);
        hold(0, 36);
        check_eq("hold_down_xfers", xfers, exp_rep);
        check_eq("hold_down_code", (xfer_log.size() > 0) ? xfer_log[0] : -1, 8);

        // Randomised keys, noise and consumer stalls
        for (int n = 0; n < 150; n++) begin
            if ((n % 25) == 0) ready_mode = $urandom_range(0, 3);
            hold($urandom_range(0, 5), $urandom_range(1, 40));
        end
        ready_mode = 1;
        hold(0, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
